// File: rtl/life_ctrl_fsm.sv
// Board controller FSM: load, read/write sweeps over DEPTH cells, generation
// counting to MAX_GEN, pause, and abort. State/count/gen registered, strobes decoded.
module life_ctrl_fsm #(
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 512,
    parameter int GEN_W   = 8,
    parameter int MAX_GEN = 100
) (
    input  logic              i_clka,
    input  logic              i_reset,
    input  logic              i_inp,
    input  logic              i_run,
    input  logic              i_wai,
    input  logic              i_loseSig,
    output logic              o_loadData,
    output logic              o_readData,
    output logic              o_writeData,
    output logic              o_writeout,
    output logic              o_win,
    output logic              o_restart,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_count,
    output logic [GEN_W-1:0]  o_gen
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_WOUT  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [GEN_W-1:0]  GEN_LIMIT = GEN_W'(MAX_GEN);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_count, w_count_nxt, w_count_inc;
    logic [GEN_W-1:0]  r_gen, w_gen_nxt;
    logic              w_last;

    // Address wraps at the last cell, so count can never leave 0..DEPTH-1.
    assign w_last      = (r_count == LAST_ADDR);
    assign w_count_inc = w_last ? '0 : r_count + ADDR_W'(1);

    always_ff @(posedge i_clka) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_gen   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_gen   <= w_gen_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_gen_nxt   = r_gen;
        case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                if (i_inp) begin
                    w_state_nxt = S_LOAD;
                end else if (i_run) begin
                    w_state_nxt = S_READ;
                    w_gen_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (i_inp) begin
                    w_count_nxt = w_count_inc;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            end
            S_READ: begin
                if (i_loseSig) begin
                    w_state_nxt = S_LOSE;
                end else if (!i_wai) begin
                    w_count_nxt = w_count_inc;
                    if (w_last) w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_loseSig) begin
                    w_state_nxt = S_LOSE;
                end else if (!i_wai) begin
                    w_count_nxt = w_count_inc;
                    if (w_last) begin
                        w_state_nxt = S_WOUT;
                        if (r_gen != GEN_LIMIT) w_gen_nxt = r_gen + GEN_W'(1);
                    end
                end
            end
            S_WOUT: begin
                w_count_nxt = '0;
                if (i_loseSig)               w_state_nxt = S_LOSE;
                else if (r_gen == GEN_LIMIT) w_state_nxt = S_WIN;
                else                         w_state_nxt = S_READ;
            end
            S_WIN: begin
                if (!i_run) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            end
            S_LOSE: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_gen_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_gen_nxt   = '0;
            end
        endcase
    end

    // A pause masks the sweep strobes so the RAM sees no access while frozen.
    assign o_loadData  = (r_state == S_LOAD);
    assign o_readData  = (r_state == S_READ)  && !i_wai;
    assign o_writeData = (r_state == S_WRITE) && !i_wai;
    assign o_writeout  = (r_state == S_WOUT);
    assign o_win       = (r_state == S_WIN);
    assign o_restart   = (r_state == S_LOSE);
    assign o_state     = r_state;
    assign o_count     = r_count;
    assign o_gen       = r_gen;

endmodule

// File: tb/tb_life_ctrl_fsm.sv
// Self-checking bench for life_ctrl_fsm at DEPTH=4, MAX_GEN=2: vector table plus
// hand-built full-game sequence, expectations queued at drive time and checked after the edge.
module tb_life_ctrl_fsm;

    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 4;
    localparam int GEN_W   = 2;
    localparam int MAX_GEN = 2;

    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] LD = 6'b100000;
    localparam logic [5:0] RD = 6'b010000;
    localparam logic [5:0] WR = 6'b001000;
    localparam logic [5:0] WO = 6'b000100;
    localparam logic [5:0] WN = 6'b000010;
    localparam logic [5:0] RS = 6'b000001;

    typedef struct {
        logic       rst, inp, run, wai, lose;
        logic [2:0] st;
        logic [1:0] cnt;
        logic [1:0] gen;
        logic [5:0] strb;
        logic       chk_cg;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset, inp, run, wai, loseSig;
    logic              loadData, readData, writeData, writeout, win, restart;
    logic [2:0]        state;
    logic [ADDR_W-1:0] count;
    logic [GEN_W-1:0]  gen;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    life_ctrl_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .GEN_W(GEN_W), .MAX_GEN(MAX_GEN)) dut (
        .i_clka(clk), .i_reset(reset), .i_inp(inp), .i_run(run), .i_wai(wai),
        .i_loseSig(loseSig), .o_loadData(loadData), .o_readData(readData),
        .o_writeData(writeData), .o_writeout(writeout), .o_win(win), .o_restart(restart),
        .o_state(state), .o_count(count), .o_gen(gen)
    );

    function automatic vec_t mk(input logic rst, input logic i, input logic r, input logic w,
                                input logic l, input logic [2:0] st, input logic [1:0] c,
                                input logic [1:0] g, input logic [5:0] s, input logic cg = 1'b1);
        vec_t v;
        v.rst = rst; v.inp = i; v.run = r; v.wai = w; v.lose = l;
        v.st = st; v.cnt = c; v.gen = g; v.strb = s; v.chk_cg = cg;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        reset = v.rst; inp = v.inp; run = v.run; wai = v.wai; loseSig = v.lose;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".state"}, int'(state), int'(e.st));
        check({tag, ".strobes"},
              int'({loadData, readData, writeData, writeout, win, restart}), int'(e.strb));
        if (e.chk_cg) begin
            check({tag, ".count"}, int'(count), int'(e.cnt));
            check({tag, ".gen"},   int'(gen),   int'(e.gen));
        end
    endtask

    initial begin
        reset = 1'b1; inp = 1'b0; run = 1'b0; wai = 1'b0; loseSig = 1'b0;

        // reset, load with wrap, lose ignored in IDLE/LOAD
        tbl.push_back(mk(1,0,0,0,0, 0,0,0, NO));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0, NO));
        tbl.push_back(mk(0,1,0,0,0, 1,0,0, LD));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0, LD));
        tbl.push_back(mk(0,1,0,0,1, 1,2,0, LD));
        tbl.push_back(mk(0,1,0,0,0, 1,3,0, LD));
        tbl.push_back(mk(0,1,0,0,0, 1,0,0, LD));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0, LD));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, NO));
        // inp wins over run in IDLE
        tbl.push_back(mk(0,1,1,0,0, 1,0,0, LD));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, NO));
        // pause in READ at count 2
        tbl.push_back(mk(0,0,1,0,0, 2,0,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 2,1,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 2,2,0, RD));
        tbl.push_back(mk(0,0,1,1,0, 2,2,0, NO));
        tbl.push_back(mk(0,0,1,1,0, 2,2,0, NO));
        tbl.push_back(mk(0,0,1,1,0, 2,2,0, NO));
        tbl.push_back(mk(0,0,1,0,0, 2,3,0, RD));
        tbl.push_back(mk(0,0,0,0,0, 3,0,0, WR));
        tbl.push_back(mk(0,0,0,1,0, 3,0,0, NO));
        tbl.push_back(mk(0,0,0,0,0, 3,1,0, WR));
        tbl.push_back(mk(0,0,0,0,0, 3,2,0, WR));
        tbl.push_back(mk(0,0,0,0,0, 3,3,0, WR));
        tbl.push_back(mk(0,0,0,0,0, 4,0,1, WO));
        tbl.push_back(mk(0,0,0,0,0, 2,0,1, RD));
        tbl.push_back(mk(0,0,0,0,0, 2,1,1, RD));
        tbl.push_back(mk(0,0,0,0,0, 2,2,1, RD));
        tbl.push_back(mk(0,0,0,0,0, 2,3,1, RD));
        tbl.push_back(mk(0,0,0,0,0, 3,0,1, WR));
        tbl.push_back(mk(0,0,0,0,0, 3,1,1, WR));
        // lose in WRITE at count 1: one restart pulse, then gen cleared
        tbl.push_back(mk(0,0,0,0,1, 6,0,0, RS, 1'b0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, NO));
        // lose and wai together in READ
        tbl.push_back(mk(0,0,1,0,0, 2,0,0, RD));
        tbl.push_back(mk(0,0,1,1,1, 6,0,0, RS, 1'b0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, NO));
        // reset mid-WRITE beats every other input
        tbl.push_back(mk(0,0,1,0,0, 2,0,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 2,1,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 2,2,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 2,3,0, RD));
        tbl.push_back(mk(0,0,1,0,0, 3,0,0, WR));
        tbl.push_back(mk(0,0,1,0,0, 3,1,0, WR));
        tbl.push_back(mk(1,1,1,1,1, 0,0,0, NO));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, NO));

        for (int k = 0; k < tbl.size(); k++) step(tbl[k], $sformatf("vec%0d", k));

        // full game to WIN; run dropped during the second generation
        for (int g = 1; g <= MAX_GEN; g++) begin
            for (int c = 0; c < DEPTH; c++)
                step(mk(0,0,(g == 1),0,0, 2,2'(c),2'(g-1), RD), $sformatf("g%0d.rd%0d", g, c));
            for (int c = 0; c < DEPTH; c++)
                step(mk(0,0,(g == 1),0,0, 3,2'(c),2'(g-1), WR), $sformatf("g%0d.wr%0d", g, c));
            step(mk(0,0,(g == 1),0,0, 4,0,2'(g), WO), $sformatf("g%0d.wout", g));
        end
        step(mk(0,0,1,0,0, 5,0,2, WN), "win0");
        step(mk(0,0,1,1,1, 5,0,2, WN), "win_lose_ignored");
        step(mk(0,0,1,0,0, 5,0,2, WN), "win2");
        step(mk(0,0,0,0,0, 0,0,2, NO), "win_exit");
        step(mk(0,0,0,0,0, 0,0,2, NO), "idle_gen_held");
        step(mk(0,0,1,0,0, 2,0,0, RD), "rerun_gen_clear");
        step(mk(1,0,0,0,0, 0,0,0, NO), "final_reset");

        if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
